// File: rtl/pc_flow_ctrl_pkg.sv
// Shared types and constants for the program-flow controller.
package pc_flow_ctrl_pkg;

    localparam int ADDR_W      = 12;
    localparam int PAGE_W      = 8;
    localparam int STACK_DEPTH = 3;

    // Instruction sub-cycles, one clk each.
    typedef enum logic [2:0] {
        CYC_A1 = 3'd0,
        CYC_A2 = 3'd1,
        CYC_A3 = 3'd2,
        CYC_M1 = 3'd3,
        CYC_M2 = 3'd4,
        CYC_X1 = 3'd5,
        CYC_X2 = 3'd6,
        CYC_X3 = 3'd7
    } cyc_e;

    localparam logic [2:0] COMMIT_CYCLE     = CYC_X3;
    localparam logic [2:0] PRE_COMMIT_CYCLE = COMMIT_CYCLE - 3'd1;

    // One bit per request source, listed in priority order (ret highest).
    typedef struct packed {
        logic ret;
        logic call;
        logic jun;
        logic jcn;
        logic jin;
    } req_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ARMED  = 2'd1,
        ST_COMMIT = 2'd2
    } fsm_state_e;

    // True when more than one request bit is set.
    function automatic logic req_multi(input req_t r);
        logic [4:0] v;
        v = r;
        return (v & (v - 5'd1)) != 5'd0;
    endfunction

endpackage

// File: rtl/pc_flow_ctrl_if.sv
// Decoder/PC side bundle of the program-flow controller.
interface pc_flow_ctrl_if;
    import pc_flow_ctrl_pkg::*;

    logic [2:0]        cycle;
    logic [ADDR_W-1:0] pcAddr;
    logic              jumpReq;
    logic              condJmpReq;
    logic              jinReq;
    logic              callReq;
    logic              retReq;
    logic [ADDR_W-1:0] jumpAddr;
    logic [PAGE_W-1:0] pageAddr;
    logic              clrFlags;
    logic              pcLoad;
    logic [ADDR_W-1:0] pcNew;
    logic [1:0]        stackDepth;
    logic              stackOvf;
    logic              stackUnf;
    logic              reqConflict;

    modport master (
        output cycle, pcAddr, jumpReq, condJmpReq, jinReq, callReq, retReq,
               jumpAddr, pageAddr, clrFlags,
        input  pcLoad, pcNew, stackDepth, stackOvf, stackUnf, reqConflict
    );

    modport slave (
        input  cycle, pcAddr, jumpReq, condJmpReq, jinReq, callReq, retReq,
               jumpAddr, pageAddr, clrFlags,
        output pcLoad, pcNew, stackDepth, stackOvf, stackUnf, reqConflict
    );

endinterface

// File: rtl/pc_ret_stack.sv
// Circular return-address stack. A push at full depth overwrites the oldest
// entry; a pop at zero depth still returns the stale entry below sp.
module pc_ret_stack
    import pc_flow_ctrl_pkg::*;
(
    input  logic              clk,
    input  logic              rstN,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] pushAddr,
    output logic [ADDR_W-1:0] topAddr,
    output logic [1:0]        depth,
    output logic              ovfPulse,
    output logic              unfPulse
);

    logic [ADDR_W-1:0] mem [STACK_DEPTH];
    logic [1:0]        sp;
    logic [1:0]        spInc;
    logic [1:0]        spDec;

    // Modulo-3 neighbours of the stack pointer.
    always_comb begin
        spInc = (sp == 2'(STACK_DEPTH - 1)) ? 2'd0 : sp + 2'd1;
        spDec = (sp == 2'd0) ? 2'(STACK_DEPTH - 1) : sp - 2'd1;
    end

    assign topAddr  = mem[spDec];
    assign ovfPulse = push && (depth == 2'(STACK_DEPTH));
    assign unfPulse = pop && (depth == 2'd0);

    // Pointer, depth and storage update; push takes precedence over pop.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            for (int i = 0; i < STACK_DEPTH; i++) begin
                mem[i] <= '0;
            end
            sp    <= 2'd0;
            depth <= 2'd0;
        end else if (push) begin
            mem[sp] <= pushAddr;
            sp      <= spInc;
            if (depth != 2'(STACK_DEPTH)) begin
                depth <= depth + 2'd1;
            end
        end else if (pop) begin
            sp <= spDec;
            if (depth != 2'd0) begin
                depth <= depth - 2'd1;
            end
        end
    end

endmodule

// File: rtl/pc_flow_ctrl.sv
// Program-flow controller: gathers jump/call/return requests during an
// instruction and issues a single PC load on the X3 sub-cycle.
//
// state     | meaning
// ST_IDLE   | cycles 0..2, requests ignored; cycle 3 arms (and is sampled)
// ST_ARMED  | cycles 4..6, requests OR-ed into pending
// ST_COMMIT | cycle 7, pcLoad/pcNew driven, stack updated, pending cleared
//
// The state register is entered one clk ahead so that ST_COMMIT coincides
// with cycle 7 itself; the PC then captures pcNew on the X3 edge.
module pc_flow_ctrl
    import pc_flow_ctrl_pkg::*;
(
    input logic          clk,
    input logic          rstN,
    pc_flow_ctrl_if.slave bus
);

    fsm_state_e        state;
    fsm_state_e        stateNext;
    logic              armWin;
    logic              commitNow;

    req_t              curReq;
    req_t              pendReq;
    req_t              allReq;
    logic [ADDR_W-1:0] jumpLat;
    logic [PAGE_W-1:0] pageLat;
    logic [ADDR_W-1:0] effJump;
    logic [PAGE_W-1:0] effPage;

    logic              pcLoadC;
    logic [ADDR_W-1:0] pcNewC;
    logic              doPush;
    logic              doPop;
    logic [ADDR_W-1:0] topAddr;
    logic [1:0]        depth;
    logic              ovfPulse;
    logic              unfPulse;
    logic              ovfFlag;
    logic              unfFlag;
    logic              confFlag;

    assign curReq = {bus.retReq, bus.callReq, bus.jumpReq, bus.condJmpReq, bus.jinReq};
    assign allReq = pendReq | curReq;

    // Targets come from the first sighting; a request first seen at X3 uses live data.
    assign effJump = (pendReq != '0) ? jumpLat : bus.jumpAddr;
    assign effPage = (pendReq != '0) ? pageLat : bus.pageAddr;

    // State register.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state <= ST_IDLE;
        end else begin
            state <= stateNext;
        end
    end

    // Next-state and window decode; any out-of-sequence cycle falls back to idle.
    always_comb begin
        stateNext = state;
        armWin    = 1'b0;
        commitNow = 1'b0;
        case (state)
            ST_IDLE: begin
                if (bus.cycle == CYC_M1) begin
                    armWin    = 1'b1;
                    stateNext = ST_ARMED;
                end
            end
            ST_ARMED: begin
                if (bus.cycle > CYC_M1 && bus.cycle < COMMIT_CYCLE) begin
                    armWin = 1'b1;
                    if (bus.cycle == PRE_COMMIT_CYCLE) begin
                        stateNext = ST_COMMIT;
                    end
                end else begin
                    stateNext = ST_IDLE;
                end
            end
            ST_COMMIT: begin
                commitNow = (bus.cycle == COMMIT_CYCLE);
                stateNext = ST_IDLE;
            end
            default: stateNext = ST_IDLE;
        endcase
    end

    // Pending requests accumulate inside the window and drop outside it.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            pendReq <= '0;
            jumpLat <= '0;
            pageLat <= '0;
        end else if (armWin) begin
            pendReq <= allReq;
            if (pendReq == '0 && curReq != '0) begin
                jumpLat <= bus.jumpAddr;
                pageLat <= bus.pageAddr;
            end
        end else begin
            pendReq <= '0;
        end
    end

    // Commit decision: highest-priority request wins.
    always_comb begin
        pcLoadC = 1'b0;
        pcNewC  = '0;
        doPush  = 1'b0;
        doPop   = 1'b0;
        if (commitNow) begin
            if (allReq.ret) begin
                pcLoadC = 1'b1;
                doPop   = 1'b1;
                pcNewC  = topAddr;
            end else if (allReq.call) begin
                pcLoadC = 1'b1;
                doPush  = 1'b1;
                pcNewC  = effJump;
            end else if (allReq.jun) begin
                pcLoadC = 1'b1;
                pcNewC  = effJump;
            end else if (allReq.jcn || allReq.jin) begin
                pcLoadC = 1'b1;
                pcNewC  = {bus.pcAddr[ADDR_W-1:PAGE_W], effPage};
            end
        end
    end

    pc_ret_stack u_stack (
        .clk      (clk),
        .rstN     (rstN),
        .push     (doPush),
        .pop      (doPop),
        .pushAddr (bus.pcAddr),
        .topAddr  (topAddr),
        .depth    (depth),
        .ovfPulse (ovfPulse),
        .unfPulse (unfPulse)
    );

    // Sticky flags; a set in the same clk as clrFlags wins.
    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            ovfFlag  <= 1'b0;
            unfFlag  <= 1'b0;
            confFlag <= 1'b0;
        end else begin
            ovfFlag  <= ovfPulse | (ovfFlag & ~bus.clrFlags);
            unfFlag  <= unfPulse | (unfFlag & ~bus.clrFlags);
            confFlag <= (commitNow && req_multi(allReq)) | (confFlag & ~bus.clrFlags);
        end
    end

    assign bus.pcLoad      = pcLoadC;
    assign bus.pcNew       = pcNewC;
    assign bus.stackDepth  = depth;
    assign bus.stackOvf    = ovfFlag;
    assign bus.stackUnf    = unfFlag;
    assign bus.reqConflict = confFlag;

endmodule

// File: tb/tb_pc_flow_ctrl.sv
// Directed bench for the program-flow controller.
module tb_pc_flow_ctrl;

    logic clk;
    logic rstN;
    int   nChecks;
    int   nFails;

    int          loadCnt;
    logic [2:0]  loadCyc;
    logic [11:0] loadVal;

    pc_flow_ctrl_if bus ();

    pc_flow_ctrl dut (
        .clk  (clk),
        .rstN (rstN),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // reqs = {ret, call, jun, jcn, jin}; data is valid only in reqCyc.
    task automatic run_instr(input int reqCyc, input logic [4:0] reqs,
                             input logic [11:0] ja, input logic [7:0] pa,
                             input logic [11:0] pc, input int rstCyc);
        loadCnt = 0;
        loadCyc = 3'd0;
        loadVal = 12'h000;
        bus.pcAddr = pc;
        for (int c = 0; c < 8; c++) begin
            bus.cycle = 3'(c);
            if (c == rstCyc) rstN = 1'b0;
            if (c == rstCyc + 1) rstN = 1'b1;
            if (c == reqCyc) begin
                {bus.retReq, bus.callReq, bus.jumpReq, bus.condJmpReq, bus.jinReq} = reqs;
                bus.jumpAddr = ja;
                bus.pageAddr = pa;
            end else begin
                {bus.retReq, bus.callReq, bus.jumpReq, bus.condJmpReq, bus.jinReq} = 5'b0;
                bus.jumpAddr = 12'hEEE;
                bus.pageAddr = 8'hEE;
            end
            @(negedge clk);
            if (bus.pcLoad === 1'b1) begin
                loadCnt++;
                loadCyc = 3'(c);
                loadVal = bus.pcNew;
            end
            @(posedge clk);
            #1;
        end
        bus.cycle = 3'd0;
        {bus.retReq, bus.callReq, bus.jumpReq, bus.condJmpReq, bus.jinReq} = 5'b0;
    endtask

    task automatic test_reset();
        @(negedge clk);
        nChecks++;
        if (bus.pcLoad !== 1'b0) begin nFails++; $display("FAIL reset_pcLoad: got %b expected 0", bus.pcLoad); end
        nChecks++;
        if (bus.pcNew !== 12'h000) begin nFails++; $display("FAIL reset_pcNew: got %h expected 000", bus.pcNew); end
        nChecks++;
        if (bus.stackDepth !== 2'd0) begin nFails++; $display("FAIL reset_depth: got %0d expected 0", bus.stackDepth); end
        nChecks++;
        if ({bus.stackOvf, bus.stackUnf, bus.reqConflict} !== 3'b000) begin
            nFails++; $display("FAIL reset_flags: got %b expected 000", {bus.stackOvf, bus.stackUnf, bus.reqConflict});
        end
        @(posedge clk);
        #1;
        rstN = 1'b1;
        @(posedge clk);
        #1;
    endtask

    task automatic test_jun();
        run_instr(4, 5'b00100, 12'h3A5, 8'h00, 12'h011, -1);
        nChecks++;
        if (loadCnt !== 1) begin nFails++; $display("FAIL jun_count: got %0d expected 1", loadCnt); end
        nChecks++;
        if (loadCyc !== 3'd7) begin nFails++; $display("FAIL jun_cycle: got %0d expected 7", loadCyc); end
        nChecks++;
        if (loadVal !== 12'h3A5) begin nFails++; $display("FAIL jun_target: got %h expected 3a5", loadVal); end
        // request outside the window
        run_instr(1, 5'b00100, 12'h123, 8'h00, 12'h011, -1);
        nChecks++;
        if (loadCnt !== 0) begin nFails++; $display("FAIL early_req_count: got %0d expected 0", loadCnt); end
    endtask

    task automatic test_call_ret();
        run_instr(5, 5'b01000, 12'h400, 8'h00, 12'h102, -1);
        nChecks++;
        if (loadVal !== 12'h400 || loadCnt !== 1) begin
            nFails++; $display("FAIL call_target: got %h x%0d expected 400 x1", loadVal, loadCnt);
        end
        nChecks++;
        if (bus.stackDepth !== 2'd1) begin nFails++; $display("FAIL call_depth: got %0d expected 1", bus.stackDepth); end
        run_instr(4, 5'b10000, 12'h000, 8'h00, 12'h402, -1);
        nChecks++;
        if (loadVal !== 12'h102 || loadCnt !== 1) begin
            nFails++; $display("FAIL ret_target: got %h x%0d expected 102 x1", loadVal, loadCnt);
        end
        nChecks++;
        if (bus.stackDepth !== 2'd0) begin nFails++; $display("FAIL ret_depth: got %0d expected 0", bus.stackDepth); end
    endtask

    task automatic test_overflow();
        logic [11:0] retExp [4];
        logic [1:0]  depExp [4];
        retExp = '{12'h040, 12'h030, 12'h020, 12'h040};
        depExp = '{2'd2, 2'd1, 2'd0, 2'd0};
        for (int k = 1; k <= 4; k++) begin
            run_instr(4, 5'b01000, 12'h100, 8'h00, 12'(k * 16), -1);
        end
        nChecks++;
        if (bus.stackOvf !== 1'b1) begin nFails++; $display("FAIL ovf_flag: got %b expected 1", bus.stackOvf); end
        nChecks++;
        if (bus.stackDepth !== 2'd3) begin nFails++; $display("FAIL ovf_depth: got %0d expected 3", bus.stackDepth); end
        for (int k = 0; k < 4; k++) begin
            nChecks++;
            if (bus.stackUnf !== 1'b0) begin nFails++; $display("FAIL unf_early[%0d]: got %b expected 0", k, bus.stackUnf); end
            run_instr(5, 5'b10000, 12'h000, 8'h00, 12'h101, -1);
            nChecks++;
            if (loadVal !== retExp[k]) begin nFails++; $display("FAIL nested_ret[%0d]: got %h expected %h", k, loadVal, retExp[k]); end
            nChecks++;
            if (bus.stackDepth !== depExp[k]) begin
                nFails++; $display("FAIL nested_depth[%0d]: got %0d expected %0d", k, bus.stackDepth, depExp[k]);
            end
        end
        nChecks++;
        if (bus.stackUnf !== 1'b1) begin nFails++; $display("FAIL unf_flag: got %b expected 1", bus.stackUnf); end
    endtask

    task automatic test_page();
        run_instr(4, 5'b00010, 12'h000, 8'h34, 12'h200, -1);
        nChecks++;
        if (loadVal !== 12'h234) begin nFails++; $display("FAIL jcn_page_edge: got %h expected 234", loadVal); end
        run_instr(6, 5'b00001, 12'h000, 8'h12, 12'h5AB, -1);
        nChecks++;
        if (loadVal !== 12'h512 || loadCnt !== 1) begin
            nFails++; $display("FAIL jin_last_window: got %h x%0d expected 512 x1", loadVal, loadCnt);
        end
    endtask

    task automatic test_conflict();
        run_instr(4, 5'b01100, 12'h777, 8'h00, 12'h300, -1);
        nChecks++;
        if (loadVal !== 12'h777) begin nFails++; $display("FAIL conflict_winner: got %h expected 777", loadVal); end
        nChecks++;
        if (bus.stackDepth !== 2'd1) begin nFails++; $display("FAIL conflict_depth: got %0d expected 1", bus.stackDepth); end
        nChecks++;
        if (bus.reqConflict !== 1'b1) begin nFails++; $display("FAIL conflict_flag: got %b expected 1", bus.reqConflict); end
        bus.clrFlags = 1'b1;
        @(posedge clk);
        #1;
        bus.clrFlags = 1'b0;
        nChecks++;
        if ({bus.stackOvf, bus.stackUnf, bus.reqConflict} !== 3'b000) begin
            nFails++; $display("FAIL clr_flags: got %b expected 000", {bus.stackOvf, bus.stackUnf, bus.reqConflict});
        end
    endtask

    task automatic test_reset_mid();
        run_instr(4, 5'b00100, 12'h6C6, 8'h00, 12'h050, 5);
        nChecks++;
        if (loadCnt !== 0) begin nFails++; $display("FAIL rst_mid_count: got %0d expected 0", loadCnt); end
        nChecks++;
        if (bus.stackDepth !== 2'd0) begin nFails++; $display("FAIL rst_mid_depth: got %0d expected 0", bus.stackDepth); end
    endtask

    task automatic test_out_of_seq();
        logic [2:0] seq [6];
        int         hits;
        seq  = '{3'd0, 3'd1, 3'd2, 3'd7, 3'd7, 3'd0};
        hits = 0;
        bus.jumpReq  = 1'b1;
        bus.jumpAddr = 12'h0F0;
        for (int i = 0; i < 6; i++) begin
            bus.cycle = seq[i];
            @(negedge clk);
            if (bus.pcLoad === 1'b1) hits++;
            @(posedge clk);
            #1;
        end
        bus.jumpReq = 1'b0;
        nChecks++;
        if (hits !== 0) begin nFails++; $display("FAIL out_of_seq_count: got %0d expected 0", hits); end
        run_instr(3, 5'b00100, 12'h0AB, 8'h00, 12'h060, -1);
        nChecks++;
        if (loadVal !== 12'h0AB || loadCnt !== 1) begin
            nFails++; $display("FAIL resync_jun: got %h x%0d expected 0ab x1", loadVal, loadCnt);
        end
    endtask

    initial begin
        nChecks = 0;
        nFails  = 0;
        rstN    = 1'b0;
        bus.cycle = 3'd0;
        bus.pcAddr = 12'h000;
        {bus.retReq, bus.callReq, bus.jumpReq, bus.condJmpReq, bus.jinReq} = 5'b0;
        bus.jumpAddr = 12'h000;
        bus.pageAddr = 8'h00;
        bus.clrFlags = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_jun();
        test_call_ret();
        test_overflow();
        test_page();
        test_conflict();
        test_reset_mid();
        test_out_of_seq();
        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule
